// File: rtl/rv32i_fwd_scoreboard_if.sv
// Bundle between the ID-stage pipeline control and the forwarding/hazard unit.
// The pipeline side drives the operand and stage information (master). The
// forwarding unit returns forward selects, stall and status (slave).
interface rv32i_fwd_scoreboard_if #(
  parameter int NSTG  = 2,
  parameter int LAT_W = 4,
  parameter int SEL_W = $clog2(NSTG + 1)
) ();

  logic                 id_valid;
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic                 rs1_used;
  logic                 rs2_used;
  logic [NSTG*5-1:0]    rd_stg;
  logic [NSTG-1:0]      regwrite_stg;
  logic [NSTG-1:0]      ready_stg;
  logic                 issue_long;
  logic [4:0]           rd_long;
  logic [LAT_W-1:0]     long_lat;
  logic                 flush;
  logic [SEL_W-1:0]     forwardA;
  logic [SEL_W-1:0]     forwardB;
  logic                 stall;
  logic                 busy;
  logic [15:0]          stall_cnt;

  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used, rs2_used,
           rd_stg, regwrite_stg, ready_stg,
           issue_long, rd_long, long_lat, flush,
    input  forwardA, forwardB, stall, busy, stall_cnt
  );

  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used,
           rd_stg, regwrite_stg, ready_stg,
           issue_long, rd_long, long_lat, flush,
    output forwardA, forwardB, stall, busy, stall_cnt
  );

endinterface

// File: rtl/rv32i_fwd_scoreboard.sv
// Forwarding and hazard unit for the RV32I pipeline. Resolves both source
// operands against NSTG downstream stages with nearest-stage priority, detects
// not-ready (load-use) hazards, and tracks outstanding long-latency writes in
// a per-register countdown scoreboard. A counter reaching zero means the long
// result has been written to the regfile and may be read from there.
module rv32i_fwd_scoreboard #(
  parameter int NSTG  = 2,
  parameter int LAT_W = 4,
  parameter int SEL_W = $clog2(NSTG + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_fwd_scoreboard_if.slave bus
);

  // Entry 0 exists only so x0 can be indexed directly; it is held at zero.
  logic [LAT_W-1:0] cnt [32];

  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic             nrdy_a;
  logic             nrdy_b;
  logic             pend_a;
  logic             pend_b;
  logic             waw;
  logic             stall_w;
  logic             id_fire;
  logic             load_long;
  logic [LAT_W-1:0] load_val;
  logic             busy_w;
  logic [15:0]      stall_cnt_q;

  // Scan from the farthest stage inwards so the nearest matching stage wins.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    nrdy_a = 1'b0;
    nrdy_b = 1'b0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (bus.rs1_used && bus.regwrite_stg[k] &&
          (bus.rd_stg[5*k +: 5] != 5'd0) && (bus.rd_stg[5*k +: 5] == bus.rs1_id)) begin
        sel_a  = SEL_W'(k + 1);
        nrdy_a = ~bus.ready_stg[k];
      end
      if (bus.rs2_used && bus.regwrite_stg[k] &&
          (bus.rd_stg[5*k +: 5] != 5'd0) && (bus.rd_stg[5*k +: 5] == bus.rs2_id)) begin
        sel_b  = SEL_W'(k + 1);
        nrdy_b = ~bus.ready_stg[k];
      end
    end
  end

  // Hazard detection against the scoreboard and the stall/issue decision.
  always_comb begin
    pend_a    = bus.rs1_used && (cnt[bus.rs1_id] != '0);
    pend_b    = bus.rs2_used && (cnt[bus.rs2_id] != '0);
    waw       = bus.issue_long && (bus.rd_long != 5'd0) && (cnt[bus.rd_long] != '0);
    stall_w   = bus.id_valid && !bus.flush && (nrdy_a || pend_a || nrdy_b || pend_b || waw);
    id_fire   = bus.id_valid && !bus.flush && !stall_w;
    load_long = id_fire && bus.issue_long && (bus.rd_long != 5'd0);
    load_val  = (bus.long_lat == '0) ? LAT_W'(1) : bus.long_lat;
  end

  // Load the issuing long op's counter; every other pending counter counts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < 32; i++) begin
        if (load_long && (bus.rd_long == 5'(i))) begin
          cnt[i] <= load_val;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LAT_W'(1);
        end
      end
    end
  end

  // Any pending entry keeps the unit busy.
  always_comb begin
    busy_w = 1'b0;
    for (int i = 1; i < 32; i++) busy_w = busy_w | (cnt[i] != '0);
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_w && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.forwardA  = sel_a;
  assign bus.forwardB  = sel_b;
  assign bus.stall     = stall_w;
  assign bus.busy      = busy_w;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rv32i_fwd_scoreboard.sv
// Testbench for rv32i_fwd_scoreboard with three forwarding stages: a table of
// combinational forwarding vectors, hand-written multi-cycle sequences, and a
// randomized run checked against a due-cycle reference model.
module tb_rv32i_fwd_scoreboard;

  localparam int NSTG  = 3;
  localparam int LAT_W = 4;

  typedef struct {
    logic        id_valid;
    logic        flush;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_long;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rd_long;
    logic [14:0] rd_stg;
    logic [2:0]  regwrite_stg;
    logic [2:0]  ready_stg;
    logic [3:0]  long_lat;
    logic [1:0]  exp_fa;
    logic [1:0]  exp_fb;
    logic        exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  rv32i_fwd_scoreboard_if #(.NSTG(NSTG), .LAT_W(LAT_W)) bus ();

  rv32i_fwd_scoreboard #(.NSTG(NSTG), .LAT_W(LAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle number from which each register is readable again,
  // plus the expected stall count.
  int unsigned due [32];
  int unsigned now;
  int unsigned sc;

  function automatic vec_t idle_vec();
    vec_t v;
    v.id_valid = 0; v.flush = 0; v.rs1_used = 0; v.rs2_used = 0; v.issue_long = 0;
    v.rs1_id = 0; v.rs2_id = 0; v.rd_long = 0; v.rd_stg = 0;
    v.regwrite_stg = 0; v.ready_stg = 3'b111; v.long_lat = 0;
    v.exp_fa = 0; v.exp_fb = 0; v.exp_stall = 0;
    return v;
  endfunction

  function automatic bit model_pending(input logic [4:0] r);
    return (r != 5'd0) && (due[r] > now);
  endfunction

  function automatic logic model_busy();
    logic b;
    b = 1'b0;
    for (int r = 1; r < 32; r++) if (due[r] > now) b = 1'b1;
    return b;
  endfunction

  function automatic void src_eval(input vec_t v, input logic [4:0] r, input logic used,
                                   output logic [1:0] sel, output bit haz);
    bit found;
    sel = 2'd0;
    haz = 1'b0;
    found = 1'b0;
    if (used && r != 5'd0) begin
      for (int k = 0; k < NSTG; k++) begin
        if (!found && v.regwrite_stg[k] && v.rd_stg[5*k +: 5] == r) begin
          found = 1'b1;
          sel = 2'(k + 1);
          haz = !v.ready_stg[k];
        end
      end
      if (model_pending(r)) haz = 1'b1;
    end
  endfunction

  function automatic void model_eval(input vec_t v, output logic [1:0] fa,
                                     output logic [1:0] fb, output logic st);
    bit h1, h2, hw;
    src_eval(v, v.rs1_id, v.rs1_used, fa, h1);
    src_eval(v, v.rs2_id, v.rs2_used, fb, h2);
    hw = v.issue_long && model_pending(v.rd_long);
    st = v.id_valid && !v.flush && (h1 || h2 || hw);
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.id_valid     = v.id_valid;
    bus.flush        = v.flush;
    bus.rs1_id       = v.rs1_id;
    bus.rs2_id       = v.rs2_id;
    bus.rs1_used     = v.rs1_used;
    bus.rs2_used     = v.rs2_used;
    bus.rd_stg       = v.rd_stg;
    bus.regwrite_stg = v.regwrite_stg;
    bus.ready_stg    = v.ready_stg;
    bus.issue_long   = v.issue_long;
    bus.rd_long      = v.rd_long;
    bus.long_lat     = v.long_lat;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One ID cycle: drive, sample at the falling edge, advance the model, clock.
  task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
    logic [1:0] mfa, mfb;
    logic       mst;
    int unsigned l;
    applyStimulus(v);
    @(negedge clk);
    model_eval(v, mfa, mfb, mst);
    if (use_model) begin
      v.exp_fa = mfa; v.exp_fb = mfb; v.exp_stall = mst;
    end
    checkOutput({tag, ".forwardA"}, 32'(bus.forwardA), 32'(v.exp_fa));
    checkOutput({tag, ".forwardB"}, 32'(bus.forwardB), 32'(v.exp_fb));
    checkOutput({tag, ".stall"}, 32'(bus.stall), 32'(v.exp_stall));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(model_busy()));
    checkOutput({tag, ".stall_cnt"}, 32'(bus.stall_cnt), sc);
    if (v.id_valid && !v.flush && !mst && v.issue_long && v.rd_long != 5'd0) begin
      l = (v.long_lat == 4'd0) ? 1 : int'(v.long_lat);
      due[v.rd_long] = now + 1 + l;
    end
    if (mst && sc < 65535) sc++;
    @(posedge clk);
    now++;
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  vec_t cons;
  int unsigned sc_before;

  initial begin
    for (int r = 0; r < 32; r++) due[r] = 0;
    now = 0;
    sc  = 0;
    rst_n = 1'b0;
    applyStimulus(idle_vec());
    #3;
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    checkOutput("reset.stall", 32'(bus.stall), 32'd0);
    checkOutput("reset.forwardA", 32'(bus.forwardA), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- combinational forwarding vectors, scoreboard empty ----
    v = idle_vec(); tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 5; v.rs1_used = 1;
    v.rd_stg = {5'd5, 5'd0, 5'd5}; v.regwrite_stg = 3'b101; v.exp_fa = 1; tbl.push_back(v);
    v.rd_stg = {5'd5, 5'd0, 5'd6}; v.exp_fa = 3; tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 0; v.rs1_used = 1;
    v.rd_stg = {5'd0, 5'd0, 5'd0}; v.regwrite_stg = 3'b001; tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs2_id = 7; v.rs2_used = 0;
    v.rd_stg = {5'd0, 5'd0, 5'd7}; v.regwrite_stg = 3'b001; tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs2_id = 7; v.rs2_used = 1;
    v.rd_stg = {5'd0, 5'd7, 5'd0}; v.regwrite_stg = 3'b010; v.exp_fb = 2; tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 8; v.rs1_used = 1;
    v.rd_stg = {5'd0, 5'd8, 5'd8}; v.regwrite_stg = 3'b011; v.ready_stg = 3'b110;
    v.exp_fa = 1; v.exp_stall = 1; tbl.push_back(v);
    v.flush = 1; v.exp_stall = 0; tbl.push_back(v);
    v.flush = 0; v.id_valid = 0; tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 3; v.rs1_used = 1; v.rs2_id = 3; v.rs2_used = 1;
    v.rd_stg = {5'd3, 5'd3, 5'd0}; v.regwrite_stg = 3'b110; v.exp_fa = 1; v.exp_fb = 2;
    v.rd_stg = {5'd3, 5'd1, 5'd3}; v.regwrite_stg = 3'b101; v.rs2_used = 0; v.exp_fb = 0;
    tbl.push_back(v);
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 5; v.rs1_used = 1;
    v.rd_stg = {5'd0, 5'd0, 5'd5}; v.regwrite_stg = 3'b000; tbl.push_back(v);

    foreach (tbl[i]) run_cycle(tbl[i], 1'b0, $sformatf("table[%0d]", i));

    // ---- load-use: one stall, then forward from stage 1 ----
    sc_before = sc;
    v = idle_vec(); v.id_valid = 1; v.rs2_id = 9; v.rs2_used = 1;
    v.rd_stg = {5'd0, 5'd0, 5'd9}; v.regwrite_stg = 3'b001; v.ready_stg = 3'b110;
    v.exp_fb = 1; v.exp_stall = 1;
    run_cycle(v, 1'b0, "loaduse.c0");
    v.rd_stg = {5'd0, 5'd9, 5'd0}; v.regwrite_stg = 3'b010; v.ready_stg = 3'b111;
    v.exp_fb = 2; v.exp_stall = 0;
    run_cycle(v, 1'b0, "loaduse.c1");
    checkOutput("loaduse.stall_cnt", 32'(bus.stall_cnt), sc_before + 1);

    // ---- long-latency RAW: latency 3 costs 3 stall cycles ----
    v = idle_vec(); v.id_valid = 1; v.issue_long = 1; v.rd_long = 12; v.long_lat = 3;
    run_cycle(v, 1'b0, "raw.issue");
    checkOutput("raw.busy_after_issue", 32'(bus.busy), 32'd1);
    cons = idle_vec(); cons.id_valid = 1; cons.rs1_id = 12; cons.rs1_used = 1; cons.exp_stall = 1;
    for (int i = 0; i < 3; i++) run_cycle(cons, 1'b0, $sformatf("raw.wait%0d", i));
    cons.exp_stall = 0;
    run_cycle(cons, 1'b0, "raw.issue_dep");
    checkOutput("raw.busy_done", 32'(bus.busy), 32'd0);

    // ---- WAW with flush first: flush must not reload the counter ----
    v = idle_vec(); v.id_valid = 1; v.issue_long = 1; v.rd_long = 4; v.long_lat = 3;
    run_cycle(v, 1'b0, "waw.first");
    v.long_lat = 5; v.flush = 1;
    run_cycle(v, 1'b0, "waw.flushed");
    v.flush = 0; v.exp_stall = 1;
    run_cycle(v, 1'b0, "waw.stall0");
    run_cycle(v, 1'b0, "waw.stall1");
    v.exp_stall = 0;
    run_cycle(v, 1'b0, "waw.fire");
    for (int i = 0; i < 6; i++) run_cycle(idle_vec(), 1'b1, "waw.drain");
    checkOutput("waw.busy_drained", 32'(bus.busy), 32'd0);

    // ---- latency 0 behaves as latency 1 ----
    v = idle_vec(); v.id_valid = 1; v.issue_long = 1; v.rd_long = 20; v.long_lat = 0;
    run_cycle(v, 1'b0, "lat0.issue");
    cons = idle_vec(); cons.id_valid = 1; cons.rs2_id = 20; cons.rs2_used = 1; cons.exp_stall = 1;
    run_cycle(cons, 1'b0, "lat0.wait");
    cons.exp_stall = 0;
    run_cycle(cons, 1'b0, "lat0.go");

    // ---- asynchronous reset mid-countdown ----
    v = idle_vec(); v.id_valid = 1; v.issue_long = 1; v.rd_long = 15; v.long_lat = 10;
    run_cycle(v, 1'b0, "rst.issue");
    v = idle_vec(); v.id_valid = 1; v.rs1_id = 15; v.rs1_used = 1; v.exp_stall = 1;
    run_cycle(v, 1'b0, "rst.wait");
    applyStimulus(idle_vec());
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.busy_async", 32'(bus.busy), 32'd0);
    checkOutput("rst.stall_cnt_async", 32'(bus.stall_cnt), 32'd0);
    for (int r = 0; r < 32; r++) due[r] = 0;
    sc = 0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    now++;
    #1;
    v.exp_stall = 0;
    run_cycle(v, 1'b0, "rst.reader");

    // ---- randomized run against the reference model ----
    for (int n = 0; n < 400; n++) begin
      v = idle_vec();
      v.id_valid     = ($urandom_range(0, 7) != 0);
      v.flush        = ($urandom_range(0, 7) == 0);
      v.rs1_id       = 5'($urandom_range(0, 7));
      v.rs2_id       = 5'($urandom_range(0, 7));
      v.rs1_used     = 1'($urandom_range(0, 1));
      v.rs2_used     = 1'($urandom_range(0, 1));
      v.rd_stg       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      v.regwrite_stg = 3'($urandom_range(0, 7));
      v.ready_stg    = 3'($urandom_range(0, 7));
      v.issue_long   = ($urandom_range(0, 3) == 0);
      v.rd_long      = 5'($urandom_range(0, 7));
      v.long_lat     = 4'($urandom_range(0, 6));
      run_cycle(v, 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
